// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: sprite geometry,
// the layout of a RAM's position word, and the RGB colour type.
package sprite_pkg;

  localparam int SPRITE_SIZE = 16;
  localparam int POS_W       = 10;
  localparam int X_LSB       = 0;
  localparam int Y_LSB       = 10;
  localparam int EN_BIT      = 20;

  typedef logic [23:0] rgb_t;

  typedef struct packed {
    logic             en;
    logic [POS_W-1:0] y;
    logic [POS_W-1:0] x;
  } sprite_pos_t;

  // Word 0 of a sprite RAM carries {en, y, x} in its low 21 bits.
  function automatic sprite_pos_t pos_from_word(input logic [31:0] word);
    sprite_pos_t p;
    p.x  = word[X_LSB +: POS_W];
    p.y  = word[Y_LSB +: POS_W];
    p.en = word[EN_BIT];
    return p;
  endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// Combinational coverage test of one pixel against one shadowed sprite
// position, producing the RAM's row/column offsets when the pixel is covered.
module sprite_hit_calc
  import sprite_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               pixel_valid,
  input  sprite_pos_t        pos,
  output logic               hit,
  output logic [3:0]         rel_x,
  output logic [3:0]         rel_y
);

  // One extra bit so a sprite near the right/bottom edge never wraps to 0.
  localparam int EW = COORD_W + 1;

  logic [EW-1:0] px, py, sx, sy, dx, dy;
  logic          in_x, in_y;

  always_comb begin
    px    = {1'b0, pixel_x};
    py    = {1'b0, pixel_y};
    sx    = EW'(pos.x);
    sy    = EW'(pos.y);
    dx    = px - sx;
    dy    = py - sy;
    in_x  = (px >= sx) && (px < sx + EW'(SPRITE_SIZE));
    in_y  = (py >= sy) && (py < sy + EW'(SPRITE_SIZE));
    hit   = pos.en && pixel_valid && in_x && in_y;
    rel_x = hit ? dx[3:0] : 4'd0;
    rel_y = hit ? dy[3:0] : 4'd0;
  end

  wire unused_diff = ^{dx[EW-1:4], dy[EW-1:4]};

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: stage A hit-tests against per-frame shadowed
// positions, stage B picks the highest-priority opaque pixel.
// Optional sticky collision flags are built when SPRITE_COLLISION_EN is defined.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES     = 5,
  parameter logic [23:0] TRANSPARENT_KEY = 24'hFF00FF,
  parameter int          COORD_W         = 10
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [COORD_W-1:0]        pixel_x,
  input  logic [COORD_W-1:0]        pixel_y,
  input  logic                      pixel_valid,
  input  logic                      frame_start,
  input  logic [32*NUM_SPRITES-1:0] sprite_data,
  output logic [NUM_SPRITES-1:0]    in_sprite,
  output logic [4*NUM_SPRITES-1:0]  rel_x,
  output logic [4*NUM_SPRITES-1:0]  rel_y,
  input  logic [32*NUM_SPRITES-1:0] sprite_pixel,
  output logic                      out_valid,
  output logic                      out_hit,
  output logic [23:0]               out_colour,
  output logic [2:0]                out_id,
  output logic [NUM_SPRITES-1:0]    collision
);

  sprite_pos_t               shadow_reg [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]    hit_c;
  logic [3:0]                rel_x_c [NUM_SPRITES];
  logic [3:0]                rel_y_c [NUM_SPRITES];

  logic                      v_a_reg;
  logic [NUM_SPRITES-1:0]    in_sprite_reg;
  logic [4*NUM_SPRITES-1:0]  rel_x_reg;
  logic [4*NUM_SPRITES-1:0]  rel_y_reg;

  logic                      out_valid_reg;
  logic                      out_hit_reg;
  rgb_t                      out_colour_reg;
  logic [2:0]                out_id_reg;

  logic [NUM_SPRITES-1:0]    opaque_c;
  logic                      win_found_c;
  logic [2:0]                win_idx_c;
  rgb_t                      win_rgb_c;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
      sprite_hit_calc #(
        .COORD_W (COORD_W)
      ) u_hit (
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_valid (pixel_valid),
        .pos         (shadow_reg[gi]),
        .hit         (hit_c[gi]),
        .rel_x       (rel_x_c[gi]),
        .rel_y       (rel_y_c[gi])
      );

      wire unused_hi = ^{sprite_data[32*gi+21 +: 11], sprite_pixel[32*gi+24 +: 8]};
    end
  endgenerate

  // Positions only change at frame_start, so a frame is never torn by CPU writes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_SPRITES; i++) shadow_reg[i] <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < NUM_SPRITES; i++)
        shadow_reg[i] <= pos_from_word(sprite_data[32*i +: 32]);
    end
  end

  // Stage A: RAM addressing.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      v_a_reg       <= 1'b0;
      in_sprite_reg <= '0;
      rel_x_reg     <= '0;
      rel_y_reg     <= '0;
    end else begin
      v_a_reg       <= pixel_valid;
      in_sprite_reg <= hit_c;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        rel_x_reg[4*i +: 4] <= rel_x_c[i];
        rel_y_reg[4*i +: 4] <= rel_y_c[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++)
      opaque_c[i] = in_sprite_reg[i] && (rgb_t'(sprite_pixel[32*i +: 24]) != TRANSPARENT_KEY);
  end

  // Scan from the lowest priority upward so the lowest opaque index wins.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = 3'd0;
    win_rgb_c   = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque_c[i]) begin
        win_found_c = 1'b1;
        win_idx_c   = 3'(i);
        win_rgb_c   = sprite_pixel[32*i +: 24];
      end
    end
  end

  // Stage B: registered colour towards the VGA mixer.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      out_valid_reg  <= 1'b0;
      out_hit_reg    <= 1'b0;
      out_colour_reg <= '0;
      out_id_reg     <= 3'd0;
    end else begin
      out_valid_reg  <= v_a_reg;
      out_hit_reg    <= v_a_reg && win_found_c;
      out_colour_reg <= (v_a_reg && win_found_c) ? win_rgb_c : '0;
      out_id_reg     <= (v_a_reg && win_found_c) ? win_idx_c : 3'd0;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] collision_reg;
  logic                   multi_c;

  assign multi_c = |(opaque_c & (opaque_c - NUM_SPRITES'(1)));

  // A set in the frame_start cycle survives the clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      collision_reg <= '0;
    else
      collision_reg <= (frame_start ? '0 : collision_reg) | (multi_c ? opaque_c : '0);
  end

  assign collision = collision_reg;
`else
  assign collision = '0;
`endif

  assign in_sprite  = in_sprite_reg;
  assign rel_x      = rel_x_reg;
  assign rel_y      = rel_y_reg;
  assign out_valid  = out_valid_reg;
  assign out_hit    = out_hit_reg;
  assign out_colour = out_colour_reg;
  assign out_id     = out_id_reg;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios plus a
// randomized run against a pixel-level reference model.
module tb_sprite_compositor;

  localparam int          NS  = 5;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b1;
  logic [9:0]      pixel_x = '0;
  logic [9:0]      pixel_y = '0;
  logic            pixel_valid = 1'b0;
  logic            frame_start = 1'b0;
  logic [32*NS-1:0] sprite_data;
  logic [NS-1:0]   in_sprite;
  logic [4*NS-1:0] rel_x;
  logic [4*NS-1:0] rel_y;
  logic [32*NS-1:0] sprite_pixel;
  logic            out_valid;
  logic            out_hit;
  logic [23:0]     out_colour;
  logic [2:0]      out_id;
  logic [NS-1:0]   collision;

  always #5 HCLK = ~HCLK;

  sprite_compositor #(
    .NUM_SPRITES     (NS),
    .TRANSPARENT_KEY (KEY),
    .COORD_W         (10)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_valid  (pixel_valid),
    .frame_start  (frame_start),
    .sprite_data  (sprite_data),
    .in_sprite    (in_sprite),
    .rel_x        (rel_x),
    .rel_y        (rel_y),
    .sprite_pixel (sprite_pixel),
    .out_valid    (out_valid),
    .out_hit      (out_hit),
    .out_colour   (out_colour),
    .out_id       (out_id),
    .collision    (collision)
  );

  // CPU-visible position words and sprite images (the RAM contents).
  logic [9:0]  sd_x [NS];
  logic [9:0]  sd_y [NS];
  logic        sd_en [NS];
  logic [23:0] img [NS][256];

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      sprite_data[32*s +: 32]  = {11'h2A5, sd_en[s], sd_y[s], sd_x[s]};
      sprite_pixel[32*s +: 32] = {8'h3C, img[s][{rel_y[4*s +: 4], rel_x[4*s +: 4]}]};
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model state: latched positions and the pixel awaiting colour lookup.
  int m_sx [NS];
  int m_sy [NS];
  bit m_en [NS];
  bit m_va;
  bit m_in [NS];
  int m_rx [NS];
  int m_ry [NS];

  bit              e_valid, e_hit;
  logic [23:0]     e_colour;
  logic [2:0]      e_id;
  logic [NS-1:0]   e_in, e_coll;
  logic [4*NS-1:0] e_rx, e_ry;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_sx[s] = 0; m_sy[s] = 0; m_en[s] = 0;
      m_in[s] = 0; m_rx[s] = 0; m_ry[s] = 0;
    end
    m_va = 0; e_valid = 0; e_hit = 0; e_colour = '0; e_id = '0;
    e_in = '0; e_coll = '0; e_rx = '0; e_ry = '0;
  endtask

  task automatic fill(input int s, input logic [23:0] c);
    for (int i = 0; i < 256; i++) img[s][i] = c;
  endtask

  task automatic disable_all();
    for (int s = 0; s < NS; s++) begin
      sd_en[s] = 1'b0; sd_x[s] = '0; sd_y[s] = '0;
    end
  endtask

  // Present one pixel for one clock; afterwards e_* hold the expected outputs.
  task automatic step(input bit v, input int x, input int y, input bit fs);
    int best, nopq;
    logic [NS-1:0] opq;
    bit hit;
    @(negedge HCLK);
    pixel_valid = v;
    pixel_x     = x[9:0];
    pixel_y     = y[9:0];
    frame_start = fs;
    best = -1; nopq = 0; opq = '0;
    for (int s = 0; s < NS; s++) begin
      if (m_in[s] && img[s][m_ry[s]*16 + m_rx[s]] != KEY) begin
        opq[s] = 1'b1;
        nopq++;
        if (best < 0) best = s;
      end
    end
    e_valid = m_va;
    e_hit = m_va && (best >= 0);
    e_colour = '0;
    e_id = '0;
    if (e_hit) begin
      e_colour = img[best][m_ry[best]*16 + m_rx[best]];
      e_id = 3'(best);
    end
`ifdef SPRITE_COLLISION_EN
    if (fs) e_coll = '0;
    if (nopq >= 2) e_coll = e_coll | opq;
`else
    e_coll = '0;
`endif
    e_in = '0; e_rx = '0; e_ry = '0;
    for (int s = 0; s < NS; s++) begin
      hit = m_en[s] && v && x >= m_sx[s] && x < m_sx[s] + 16 && y >= m_sy[s] && y < m_sy[s] + 16;
      m_in[s] = hit;
      m_rx[s] = hit ? x - m_sx[s] : 0;
      m_ry[s] = hit ? y - m_sy[s] : 0;
      e_in[s] = hit;
      e_rx[4*s +: 4] = 4'(m_rx[s]);
      e_ry[4*s +: 4] = 4'(m_ry[s]);
    end
    m_va = v;
    if (fs) begin
      for (int s = 0; s < NS; s++) begin
        m_sx[s] = int'(sd_x[s]); m_sy[s] = int'(sd_y[s]); m_en[s] = sd_en[s];
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    disable_all();
    for (int s = 0; s < NS; s++) begin
      sd_en[s] = 1'b1;
      fill(s, 24'h123456);
    end
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_hit !== 1'b0 || out_colour !== 24'h0 || out_id !== 3'd0) begin bad++; $display("FAIL reset_out_fields got=%b/%h/%0d want=0/0/0", out_hit, out_colour, out_id); end
    total++; if (in_sprite !== '0 || rel_x !== '0 || rel_y !== '0) begin bad++; $display("FAIL reset_stage_a got=%b/%h/%h want=0", in_sprite, rel_x, rel_y); end
    total++; if (collision !== '0) begin bad++; $display("FAIL reset_collision got=%b want=0", collision); end
    @(negedge HCLK);
    HRESET = 1'b0;
    model_reset();
    step(1, 5, 5, 0);
    total++; if (in_sprite !== 5'b00000) begin bad++; $display("FAIL reset_no_shadow got=%b want=00000", in_sprite); end
    step(0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_hit !== 1'b0) begin bad++; $display("FAIL reset_first_pixel got=%b/%b want=1/0", out_valid, out_hit); end
  endtask

  task automatic test_single();
    disable_all();
    sd_x[0] = 10'd100; sd_y[0] = 10'd50; sd_en[0] = 1'b1;
    fill(0, 24'hFFFF00);
    step(0, 0, 0, 1);
    step(1, 107, 53, 0);
    total++; if (in_sprite !== 5'b00001) begin bad++; $display("FAIL single_in_sprite got=%b want=00001", in_sprite); end
    total++; if (rel_x[3:0] !== 4'd7 || rel_y[3:0] !== 4'd3) begin bad++; $display("FAIL single_rel got=%0d,%0d want=7,3", rel_x[3:0], rel_y[3:0]); end
    step(0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_hit !== 1'b1 || out_colour !== 24'hFFFF00 || out_id !== 3'd0) begin
      bad++; $display("FAIL single_out got=%b/%b/%h/%0d want=1/1/ffff00/0", out_valid, out_hit, out_colour, out_id); end
  endtask

  task automatic test_priority();
    disable_all();
    sd_x[1] = 10'd200; sd_y[1] = 10'd200; sd_en[1] = 1'b1;
    sd_x[3] = 10'd200; sd_y[3] = 10'd200; sd_en[3] = 1'b1;
    fill(1, 24'h112233);
    fill(3, 24'h445566);
    step(0, 0, 0, 1);
    step(1, 205, 210, 0);
    total++; if (in_sprite !== 5'b01010) begin bad++; $display("FAIL prio_in_sprite got=%b want=01010", in_sprite); end
    step(0, 0, 0, 0);
    total++; if (out_id !== 3'd1 || out_colour !== 24'h112233) begin bad++; $display("FAIL prio_both_opaque got=%0d/%h want=1/112233", out_id, out_colour); end
    img[1][10*16 + 5] = KEY;
    step(1, 205, 210, 0);
    step(0, 0, 0, 0);
    total++; if (out_hit !== 1'b1 || out_id !== 3'd3 || out_colour !== 24'h445566) begin bad++; $display("FAIL prio_transparent_top got=%b/%0d/%h want=1/3/445566", out_hit, out_id, out_colour); end
    img[3][10*16 + 5] = KEY;
    step(1, 205, 210, 0);
    step(0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_hit !== 1'b0 || out_colour !== 24'h0 || out_id !== 3'd0) begin bad++; $display("FAIL prio_all_transparent got=%b/%b/%h/%0d want=1/0/0/0", out_valid, out_hit, out_colour, out_id); end
  endtask

  task automatic test_shadow();
    disable_all();
    sd_x[2] = 10'd100; sd_y[2] = 10'd0; sd_en[2] = 1'b1;
    fill(2, 24'h0000AA);
    step(0, 0, 0, 1);
    sd_x[2] = 10'd300;
    step(1, 105, 5, 0);
    total++; if (in_sprite !== 5'b00100) begin bad++; $display("FAIL shadow_old_x got=%b want=00100", in_sprite); end
    step(1, 305, 5, 0);
    total++; if (in_sprite !== 5'b00000) begin bad++; $display("FAIL shadow_new_x_early got=%b want=00000", in_sprite); end
    step(1, 105, 5, 1);
    total++; if (in_sprite !== 5'b00100) begin bad++; $display("FAIL shadow_same_cycle got=%b want=00100", in_sprite); end
    step(1, 305, 5, 0);
    total++; if (in_sprite !== 5'b00100 || rel_x[11:8] !== 4'd5) begin bad++; $display("FAIL shadow_moved got=%b/%0d want=00100/5", in_sprite, rel_x[11:8]); end
    step(1, 105, 5, 0);
    total++; if (in_sprite !== 5'b00000) begin bad++; $display("FAIL shadow_old_gone got=%b want=00000", in_sprite); end
  endtask

  task automatic test_edge();
    disable_all();
    sd_x[4] = 10'd1015; sd_y[4] = 10'd0; sd_en[4] = 1'b1;
    fill(4, 24'h00CC00);
    step(0, 0, 0, 1);
    step(1, 1023, 0, 0);
    total++; if (in_sprite !== 5'b10000 || rel_x[19:16] !== 4'd8) begin bad++; $display("FAIL edge_right got=%b/%0d want=10000/8", in_sprite, rel_x[19:16]); end
    step(0, 0, 0, 0);
    total++; if (out_hit !== 1'b1 || out_id !== 3'd4 || out_colour !== 24'h00CC00) begin bad++; $display("FAIL edge_colour got=%b/%0d/%h want=1/4/00cc00", out_hit, out_id, out_colour); end
    sd_x[4] = 10'd1020;
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    total++; if (in_sprite !== 5'b00000) begin bad++; $display("FAIL edge_no_wrap got=%b want=00000", in_sprite); end
    step(1, 1023, 15, 0);
    total++; if (in_sprite !== 5'b10000 || rel_x[19:16] !== 4'd3 || rel_y[19:16] !== 4'd15) begin bad++; $display("FAIL edge_corner got=%b/%0d/%0d want=10000/3/15", in_sprite, rel_x[19:16], rel_y[19:16]); end
    step(1, 1020, 16, 0);
    total++; if (in_sprite !== 5'b00000) begin bad++; $display("FAIL edge_below got=%b want=00000", in_sprite); end
  endtask

  task automatic test_reset_mid();
    step(1, 1021, 2, 0);
    total++; if (in_sprite !== 5'b10000) begin bad++; $display("FAIL mid_pre_hit got=%b want=10000", in_sprite); end
    HRESET = 1'b1;
    #1;
    total++; if (in_sprite !== '0 || rel_x !== '0 || out_valid !== 1'b0 || out_hit !== 1'b0) begin
      bad++; $display("FAIL mid_async_clear got=%b/%h/%b/%b want=0/0/0/0", in_sprite, rel_x, out_valid, out_hit); end
    @(negedge HCLK);
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    HRESET = 1'b0;
    model_reset();
    step(1, 1021, 2, 0);
    total++; if (out_valid !== 1'b0 || out_hit !== 1'b0) begin bad++; $display("FAIL mid_no_partial got=%b/%b want=0/0", out_valid, out_hit); end
    total++; if (in_sprite !== 5'b00000) begin bad++; $display("FAIL mid_shadow_cleared got=%b want=00000", in_sprite); end
  endtask

  task automatic test_collision();
    logic [NS-1:0] want;
`ifdef SPRITE_COLLISION_EN
    want = 5'b00101;
`else
    want = 5'b00000;
`endif
    disable_all();
    sd_x[0] = 10'd400; sd_y[0] = 10'd400; sd_en[0] = 1'b1;
    sd_x[2] = 10'd400; sd_y[2] = 10'd400; sd_en[2] = 1'b1;
    fill(0, 24'h010101);
    fill(2, 24'h020202);
    step(0, 0, 0, 1);
    step(1, 405, 405, 0);
    step(0, 0, 0, 0);
    total++; if (collision !== want) begin bad++; $display("FAIL coll_set got=%b want=%b", collision, want); end
    total++; if (out_id !== 3'd0 || out_colour !== 24'h010101) begin bad++; $display("FAIL coll_prio got=%0d/%h want=0/010101", out_id, out_colour); end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    total++; if (collision !== want) begin bad++; $display("FAIL coll_sticky got=%b want=%b", collision, want); end
    step(0, 0, 0, 1);
    total++; if (collision !== 5'b00000) begin bad++; $display("FAIL coll_clear got=%b want=00000", collision); end
    step(1, 410, 401, 0);
    step(0, 0, 0, 1);
    total++; if (collision !== want) begin bad++; $display("FAIL coll_set_wins got=%b want=%b", collision, want); end
  endtask

  task automatic randomize_sprite(input int s);
    sd_x[s]  = (s == 4) ? 10'(1008 + $urandom_range(0, 15)) : 10'(100 + $urandom_range(0, 40));
    sd_y[s]  = 10'(100 + $urandom_range(0, 40));
    sd_en[s] = ($urandom_range(0, 4) != 0);
  endtask

  task automatic test_random();
    int x, y;
    bit v, fs;
    for (int s = 0; s < NS; s++) begin
      randomize_sprite(s);
      for (int i = 0; i < 256; i++)
        img[s][i] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
    end
    step(0, 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) randomize_sprite(int'($urandom_range(0, NS-1)));
      v  = ($urandom_range(0, 9) != 0);
      fs = ($urandom_range(0, 49) == 0);
      x  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(95, 165));
      y  = int'($urandom_range(95, 160));
      step(v, x, y, fs);
      total++; if (in_sprite !== e_in || rel_x !== e_rx || rel_y !== e_ry) begin
        bad++; $display("FAIL rand_stage_a n=%0d got=%b/%h/%h want=%b/%h/%h", n, in_sprite, rel_x, rel_y, e_in, e_rx, e_ry); end
      total++; if (out_valid !== e_valid || out_hit !== e_hit || out_colour !== e_colour || out_id !== e_id) begin
        bad++; $display("FAIL rand_stage_b n=%0d got=%b/%b/%h/%0d want=%b/%b/%h/%0d", n, out_valid, out_hit, out_colour, out_id, e_valid, e_hit, e_colour, e_id); end
      total++; if (collision !== e_coll) begin
        bad++; $display("FAIL rand_collision n=%0d got=%b want=%b", n, collision, e_coll); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_shadow();
    test_edge();
    test_reset_mid();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Pipelined controller that sequences up to NUM_SPRITES 16x16 sprite RAMs against the VGA pixel stream.
- Per pixel, it decides which sprites cover the pixel and drives each RAM's in_sprite/rel_x/rel_y.
- It selects the highest-priority opaque sprite pixel and presents one registered colour to the VGA mixer.
- Sprite positions are read from each RAM's word 0 (sprite_data) and shadowed once per frame, so CPU writes never tear a frame.

Parameters:
NUM_SPRITES, 5, number of sprite RAMs served (index 0 = highest priority)
TRANSPARENT_KEY, 24'hFF00FF, RGB value treated as transparent
COORD_W, 10, width of pixel and sprite coordinates

Ports:
HCLK  in  1  system clock
HRESET  in  1  asynchronous active-high reset
pixel_x  in  COORD_W  current VGA pixel column
pixel_y  in  COORD_W  current VGA pixel row
pixel_valid  in  1  pixel_x/pixel_y are in the visible area this cycle
frame_start  in  1  one-cycle pulse at the start of vertical blank
sprite_data  in  32*NUM_SPRITES  word 0 of each RAM: [9:0]=X, [19:10]=Y, [20]=enable
in_sprite  out  NUM_SPRITES  per-RAM read strobe
rel_x  out  4*NUM_SPRITES  per-RAM column offset
rel_y  out  4*NUM_SPRITES  per-RAM row offset
sprite_pixel  in  32*NUM_SPRITES  per-RAM pixel word (combinational from RAM); [23:0]=RGB
out_valid  out  1  out_* fields valid
out_hit  out  1  an opaque sprite pixel was selected
out_colour  out  24  selected RGB; 0 when !out_hit
out_id  out  3  index of the selected sprite
collision  out  NUM_SPRITES  sticky collision flags (optional feature)

Behaviour:
- Reset (asynchronous, HRESET=1):
  - All outputs are 0.
  - Shadow positions are 0, so every sprite is disabled until the first frame_start.
  - Pipeline valid bits are cleared. Reset mid-frame discards in-flight pixels, with no partial outputs.
- Shadow latch: on a HCLK edge with frame_start=1, shadow[i] <= sprite_data[i][20:0] for all i.
  - A pixel_valid pixel in the same cycle uses the old shadow values.
- Stage A (registered, on every edge):
  - v_a <= pixel_valid.
  - Hit test, evaluated in COORD_W+1 bits so X+16 does not wrap: hit_i = en_i & pixel_valid & (x>=X_i) & (x<X_i+16) & (y>=Y_i) & (y<Y_i+16).
  - in_sprite[i] <= hit_i.
  - rel_x[i] <= (x-X_i)[3:0] and rel_y[i] <= (y-Y_i)[3:0] when hit_i, else 0.
- Each RAM returns sprite_pixel combinationally during the cycle after stage A.
- Stage B (registered):
  - out_valid <= v_a.
  - opaque_i = in_sprite[i] & (sprite_pixel[i][23:0] != TRANSPARENT_KEY).
  - The lowest index with opaque_i=1 wins: out_hit=1, out_colour=its RGB, out_id=its index.
  - If no sprite is opaque: out_hit=0, out_colour=0, out_id=0.
  - When v_a=0: out_valid=0 and out_hit=0.
- Latency: a pixel presented at edge N appears on out_* after edge N+2. Throughput is 1 pixel/cycle, with no stall.
- Boundary cases:
  - X_i >= 1024-16: columns past 1023 are never hit, and no wrap to column 0.
  - Sprites that overlap: priority is decided by index only.
  - A fully transparent sprite gives out_hit=0.
  - A sprite with enable=0 never asserts in_sprite.

Optional Feature:
SPRITE_COLLISION_EN
- Defined:
  - In stage B, if two or more opaque_i bits are set, collision[i] |= opaque_i.
  - The flags are sticky and are cleared on frame_start.
  - When a set and a clear occur in the same cycle, the set wins, so the new frame keeps the flag.
- Undefined: collision is tied to 0 and no flag registers exist.

Decomposition:
- Package sprite_pkg holds:
  - SPRITE_SIZE=16;
  - position field offsets/widths (X_LSB=0, Y_LSB=10, EN_BIT=20);
  - typedef sprite_pos_t {en, y, x};
  - typedef rgb_t (24-bit).
- Sub-module sprite_hit_calc, one instance per sprite: combinational hit test plus rel_x/rel_y computation from pixel coordinates and a shadow entry.

Test Plan:
- Reset then pixel (5,5) valid, no frame_start: out_valid=1 two cycles later, out_hit=0, all in_sprite=0.
- Sprite0 at (100,50) enabled, frame_start, then pixel (107,53):
  - in_sprite[0]=1, rel_x=7, rel_y=3 after 1 cycle.
  - With the RAM returning 0x00FFFF00: out_colour=FFFF00, out_id=0 after 2 cycles.
- Sprites 1 and 3 both at (200,200), pixel (205,210):
  - both opaque: out_id=1;
  - sprite1 pixel = FF00FF: out_id=3, colour from sprite 3.
- sprite_data changed to X=300 mid-frame: hits remain at the old X until the next frame_start pulse, then move; frame_start and pixel_valid in the same cycle use the old X.
- Sprite at X=1015, pixel x=1023: hit with rel_x=8. Sprite at X=1020, pixel x=0: no hit.
- With SPRITE_COLLISION_EN, sprites 0 and 2 overlap on opaque pixels:
  - collision=5'b00101 and it stays set through the frame;
  - cleared after frame_start;
  - without the macro, collision=0 always.
